// File: rtl/io_uart_if.sv
// CPU-side I/O bus control signals seen by the UART peripheral.
// The bidirectional data lines stay a plain inout on the peripheral.
interface io_uart_if;
    logic [3:0] io_addr;
    logic       io_oe;
    logic       io_we;

    modport master (output io_addr, io_oe, io_we);
    modport slave  (input  io_addr, io_oe, io_we);
endinterface

// File: rtl/io_uart.sv
// Memory-mapped 8N1 UART: 4-register window, 4-deep TX FIFO, RX holding register.
// TX/RX state | meaning: IDLE line idle | START start bit | DATA 8 data bits LSB first | STOP stop bit
module io_uart #(
    parameter logic [1:0] BASE      = 2'b00,
    parameter logic [7:0] DIV_RESET = 8'd15
) (
    input  logic       clk,
    input  logic       reset,
    io_uart_if.slave   bus,
    inout  wire  [7:0] io_data,
    input  logic       uart_rx,
    output logic       uart_tx
);
    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    state_t     r_tx_st, r_rx_st;
    logic [7:0] r_div;
    logic [7:0] r_fifo [4];
    logic [1:0] r_wptr, r_rptr;
    logic [2:0] r_count;
    logic [7:0] r_tx_sh, r_tx_cnt;
    logic [2:0] r_tx_bit;
    logic       r_tx;
    logic       r_rx_s1, r_rx_s2, r_rx_s3;
    logic [7:0] r_rx_sh, r_rx_cnt, r_rxdata;
    logic [2:0] r_rx_bit;
    logic       r_rxv, r_ovr, r_fe;

    logic       w_sel, w_wr, w_rd, w_wr_tx, w_wr_rx, w_wr_div;
    logic       w_full, w_empty, w_push, w_pop, w_busy, w_tx_tick;
    logic [8:0] w_div_p1;
    logic [7:0] w_half_m1, w_rdata;

    assign w_sel    = (bus.io_addr[3:2] == BASE);
    assign w_wr     = w_sel & bus.io_oe & bus.io_we;
    assign w_rd     = w_sel & ~bus.io_oe;
    assign w_wr_tx  = w_wr & (bus.io_addr[1:0] == 2'd1);
    assign w_wr_rx  = w_wr & (bus.io_addr[1:0] == 2'd2);
    assign w_wr_div = w_wr & (bus.io_addr[1:0] == 2'd3);

    assign w_full    = (r_count == 3'd4);
    assign w_empty   = (r_count == 3'd0);
    assign w_push    = w_wr_tx & ~w_full;
    assign w_tx_tick = (r_tx_cnt == 8'd0);
    // Back-to-back frames: the pop at the end of STOP feeds START directly.
    assign w_pop     = ~w_empty & ((r_tx_st == S_IDLE) | ((r_tx_st == S_STOP) & w_tx_tick));
    assign w_busy    = (r_tx_st != S_IDLE) | ~w_empty;

    assign w_div_p1  = {1'b0, r_div} + 9'd1;
    assign w_half_m1 = 8'(w_div_p1 >> 1) - 8'd1;

    always_comb begin
        w_rdata = 8'h00;
        case (bus.io_addr[1:0])
            2'd0:    w_rdata = {3'b000, r_fe, r_ovr, r_rxv, w_full, w_busy};
            2'd2:    w_rdata = r_rxdata;
            2'd3:    w_rdata = r_div;
            default: w_rdata = 8'h00;
        endcase
    end

    assign io_data = w_rd ? w_rdata : 8'bz;
    assign uart_tx = r_tx;

    always_ff @(posedge clk) begin
        if (reset)         r_div <= DIV_RESET;
        else if (w_wr_div) r_div <= io_data;
    end

    always_ff @(posedge clk) begin
        if (w_push) r_fifo[r_wptr] <= io_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr  <= 2'd0;
            r_rptr  <= 2'd0;
            r_count <= 3'd0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 2'd1;
            if (w_pop)  r_rptr <= r_rptr + 2'd1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 3'd1;
                2'b01:   r_count <= r_count - 3'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_tx_st  <= S_IDLE;
            r_tx     <= 1'b1;
            r_tx_sh  <= 8'h00;
            r_tx_cnt <= 8'd0;
            r_tx_bit <= 3'd0;
        end else begin
            case (r_tx_st)
                S_IDLE: if (w_pop) begin
                    r_tx_sh  <= r_fifo[r_rptr];
                    r_tx     <= 1'b0;
                    r_tx_cnt <= r_div;
                    r_tx_st  <= S_START;
                end
                S_START: if (w_tx_tick) begin
                    r_tx     <= r_tx_sh[0];
                    r_tx_sh  <= {1'b0, r_tx_sh[7:1]};
                    r_tx_bit <= 3'd0;
                    r_tx_cnt <= r_div;
                    r_tx_st  <= S_DATA;
                end else r_tx_cnt <= r_tx_cnt - 8'd1;
                S_DATA: if (w_tx_tick) begin
                    r_tx_cnt <= r_div;
                    if (r_tx_bit == 3'd7) begin
                        r_tx    <= 1'b1;
                        r_tx_st <= S_STOP;
                    end else begin
                        r_tx     <= r_tx_sh[0];
                        r_tx_sh  <= {1'b0, r_tx_sh[7:1]};
                        r_tx_bit <= r_tx_bit + 3'd1;
                    end
                end else r_tx_cnt <= r_tx_cnt - 8'd1;
                S_STOP: if (w_tx_tick) begin
                    r_tx_cnt <= r_div;
                    if (w_pop) begin
                        r_tx_sh <= r_fifo[r_rptr];
                        r_tx    <= 1'b0;
                        r_tx_st <= S_START;
                    end else r_tx_st <= S_IDLE;
                end else r_tx_cnt <= r_tx_cnt - 8'd1;
                default: r_tx_st <= S_IDLE;
            endcase
        end
    end

    // Acknowledge clears first; a frame completing on the same edge re-sets the flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rx_s1  <= 1'b1;
            r_rx_s2  <= 1'b1;
            r_rx_s3  <= 1'b1;
            r_rx_st  <= S_IDLE;
            r_rx_cnt <= 8'd0;
            r_rx_bit <= 3'd0;
            r_rx_sh  <= 8'h00;
            r_rxdata <= 8'h00;
            r_rxv    <= 1'b0;
            r_ovr    <= 1'b0;
            r_fe     <= 1'b0;
        end else begin
            r_rx_s1 <= uart_rx;
            r_rx_s2 <= r_rx_s1;
            r_rx_s3 <= r_rx_s2;
            if (w_wr_rx) begin
                r_rxv <= 1'b0;
                r_ovr <= 1'b0;
                r_fe  <= 1'b0;
            end
            case (r_rx_st)
                S_IDLE: if (r_rx_s3 & ~r_rx_s2) begin
                    r_rx_cnt <= w_half_m1;
                    r_rx_st  <= S_START;
                end
                S_START: if (r_rx_cnt == 8'd0) begin
                    if (r_rx_s2) r_rx_st <= S_IDLE;
                    else begin
                        r_rx_cnt <= r_div;
                        r_rx_bit <= 3'd0;
                        r_rx_st  <= S_DATA;
                    end
                end else r_rx_cnt <= r_rx_cnt - 8'd1;
                S_DATA: if (r_rx_cnt == 8'd0) begin
                    r_rx_sh  <= {r_rx_s2, r_rx_sh[7:1]};
                    r_rx_cnt <= r_div;
                    if (r_rx_bit == 3'd7) r_rx_st <= S_STOP;
                    else                  r_rx_bit <= r_rx_bit + 3'd1;
                end else r_rx_cnt <= r_rx_cnt - 8'd1;
                S_STOP: if (r_rx_cnt == 8'd0) begin
                    if (r_rx_s2) begin
                        r_rxdata <= r_rx_sh;
                        r_rxv    <= 1'b1;
                        if (r_rxv & ~w_wr_rx) r_ovr <= 1'b1;
                    end else r_fe <= 1'b1;
                    r_rx_st <= S_IDLE;
                end else r_rx_cnt <= r_rx_cnt - 8'd1;
                default: r_rx_st <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_io_uart.sv
// Directed bench for io_uart: frame-level TX model checked on every cycle plus
// hand-computed register and line expectations.
module tb_io_uart;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       uart_rx = 1'b1;
    logic       uart_tx;
    wire  [7:0] io_data;
    logic [7:0] drv = 8'h00;
    logic       drv_en = 1'b0;
    logic       chk_en = 1'b0;

    int total = 0;
    int bad = 0;

    assign io_data = drv_en ? drv : 8'bz;

    io_uart_if bus_if ();

    io_uart #(.BASE(2'b00), .DIV_RESET(8'd15)) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus_if),
        .io_data (io_data),
        .uart_rx (uart_rx),
        .uart_tx (uart_tx)
    );

    always #5 clk = ~clk;

    // Behavioural model: byte queue plus the currently transmitted 10-bit frame.
    logic [7:0] m_q [$];
    logic [9:0] m_frame = 10'h3FF;
    int         m_div = 15;
    int         m_t = 0;
    bit         m_active = 1'b0;
    logic       m_tx = 1'b1;
    bit         m_rxv = 1'b0, m_ovr = 1'b0, m_fe = 1'b0;
    logic [7:0] m_rxd = 8'h00;

    function automatic logic [7:0] m_status();
        return {3'b000, m_fe, m_ovr, m_rxv, (m_q.size() == 4), (m_active || m_q.size() != 0)};
    endfunction

    always @(posedge clk) begin
        bit         wr, was_full;
        logic [1:0] a;
        logic [7:0] d;
        if (reset) begin
            m_q.delete();
            m_active = 1'b0;
            m_t = 0;
            m_div = 15;
            m_tx = 1'b1;
            m_rxv = 1'b0; m_ovr = 1'b0; m_fe = 1'b0; m_rxd = 8'h00;
        end else begin
            wr = (bus_if.io_addr[3:2] == 2'b00) && bus_if.io_oe && bus_if.io_we;
            a = bus_if.io_addr[1:0];
            d = io_data;
            was_full = (m_q.size() == 4);
            if (m_active) begin
                m_t++;
                if (m_t == 10 * (m_div + 1)) m_active = 1'b0;
            end
            if (!m_active && m_q.size() != 0) begin
                m_frame = {1'b1, m_q.pop_front(), 1'b0};
                m_active = 1'b1;
                m_t = 0;
            end
            if (wr && a == 2'd1 && !was_full) m_q.push_back(d);
            if (wr && a == 2'd2) begin m_rxv = 1'b0; m_ovr = 1'b0; m_fe = 1'b0; end
            if (wr && a == 2'd3) m_div = int'(d);
            m_tx = m_active ? m_frame[m_t / (m_div + 1)] : 1'b1;
        end
    end

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en && !reset) check8("tx_line", {7'b0, uart_tx}, {7'b0, m_tx});
    end

    task automatic bus_idle();
        bus_if.io_addr = 4'hC;
        bus_if.io_oe = 1'b1;
        bus_if.io_we = 1'b0;
        drv_en = 1'b0;
    endtask

    task automatic bus_write(input logic [3:0] a, input logic [7:0] d);
        @(negedge clk);
        bus_if.io_addr = a; bus_if.io_oe = 1'b1; bus_if.io_we = 1'b1;
        drv = d; drv_en = 1'b1;
        @(posedge clk);
        #1 bus_idle();
    endtask

    task automatic bus_read(input logic [3:0] a, output logic [7:0] d);
        @(negedge clk);
        bus_if.io_addr = a; bus_if.io_oe = 1'b0; bus_if.io_we = 1'b0; drv_en = 1'b0;
        #1 d = io_data;
        @(posedge clk);
        #1 bus_idle();
    endtask

    // Bench drives 0 while the DUT must float; any DUT drive of a nonzero register shows.
    task automatic zcheck(input string name, input logic [3:0] a, input logic oe);
        @(negedge clk);
        bus_if.io_addr = a; bus_if.io_oe = oe; bus_if.io_we = 1'b0;
        drv = 8'h00; drv_en = 1'b1;
        #1 check8(name, io_data, 8'h00);
        @(posedge clk);
        #1 bus_idle();
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stopb, input int d);
        logic [9:0] f;
        f = {stopb, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            uart_rx = f[i];
            repeat (d) @(negedge clk);
        end
        @(negedge clk);
        uart_rx = 1'b1;
        if (stopb) begin
            if (m_rxv) m_ovr = 1'b1;
            m_rxd = b;
            m_rxv = 1'b1;
        end else m_fe = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] rd;
        logic [9:0] exp_seq;
        bus_idle();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk_en = 1'b1;

        check8("rst_tx", {7'b0, uart_tx}, 8'h01);
        bus_read(4'h0, rd); check8("rst_status", rd, 8'h00);
        bus_read(4'h3, rd); check8("rst_baud", rd, 8'h0F);
        bus_read(4'h2, rd); check8("rst_rxdata", rd, 8'h00);
        bus_read(4'h1, rd); check8("txdata_read", rd, 8'h00);

        zcheck("z_foreign_base", 4'h7, 1'b0);
        zcheck("z_other_base", 4'hB, 1'b0);
        zcheck("z_oe_high", 4'h3, 1'b1);

        @(negedge clk);
        bus_if.io_addr = 4'h3; bus_if.io_oe = 1'b1; bus_if.io_we = 1'b0;
        drv = 8'h55; drv_en = 1'b1;
        @(posedge clk);
        #1 bus_idle();
        bus_read(4'h3, rd); check8("we_low_nowrite", rd, 8'h0F);

        bus_write(4'h3, 8'd3);
        bus_read(4'h3, rd); check8("baud_wr", rd, 8'h03);

        // 0xA5 at BAUDDIV=3: mid-bit samples of the 10-bit frame
        exp_seq = 10'b1101001010;
        bus_write(4'h1, 8'hA5);
        repeat (3) @(posedge clk);
        #1 check8("a5_bit0", {7'b0, uart_tx}, {7'b0, exp_seq[0]});
        for (int k = 1; k < 10; k++) begin
            repeat (4) @(posedge clk);
            #1 check8($sformatf("a5_bit%0d", k), {7'b0, uart_tx}, {7'b0, exp_seq[k]});
        end
        @(posedge clk);
        bus_read(4'h0, rd); check8("a5_busy_last", rd, 8'h01);
        bus_read(4'h0, rd); check8("a5_busy_clear", rd, 8'h00);

        for (int i = 1; i <= 6; i++) bus_write(4'h1, 8'(i));
        bus_read(4'h0, rd);
        check8("fifo_full_model", rd, m_status());
        check8("fifo_full_lit", rd, 8'h03);
        repeat (5 * 40 + 10) @(posedge clk);
        bus_read(4'h0, rd); check8("fifo_drained", rd, 8'h00);

        // Reset during the start bit of 0xFF, with a BAUDDIV write on the reset edge
        bus_write(4'h1, 8'hFF);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check8("mid_tx_start", {7'b0, uart_tx}, 8'h00);
        reset = 1'b1;
        bus_if.io_addr = 4'h3; bus_if.io_oe = 1'b1; bus_if.io_we = 1'b1;
        drv = 8'h07; drv_en = 1'b1;
        @(posedge clk);
        #1 check8("rst_mid_tx", {7'b0, uart_tx}, 8'h01);
        bus_idle();
        @(negedge clk);
        reset = 1'b0;
        bus_read(4'h0, rd); check8("rst2_status", rd, 8'h00);
        bus_read(4'h3, rd); check8("rst2_baud", rd, 8'h0F);

        bus_write(4'h3, 8'd7);
        send_rx(8'h3C, 1'b1, 7);
        bus_read(4'h0, rd);
        check8("rx1_status", rd, m_status());
        check8("rx1_status_lit", rd, 8'h04);
        bus_read(4'h2, rd); check8("rx1_data", rd, 8'h3C);
        bus_write(4'h2, 8'h00);
        bus_read(4'h0, rd); check8("rx1_ack", rd, 8'h00);

        send_rx(8'h11, 1'b1, 7);
        send_rx(8'h22, 1'b1, 7);
        bus_read(4'h0, rd);
        check8("ovr_status", rd, m_status());
        check8("ovr_status_lit", rd, 8'h0C);
        bus_read(4'h2, rd); check8("ovr_data", rd, m_rxd);

        send_rx(8'h55, 1'b0, 7);
        bus_read(4'h0, rd); check8("fe_status", rd, 8'h1C);
        bus_read(4'h2, rd); check8("fe_data", rd, 8'h22);
        bus_write(4'h2, 8'h00);
        bus_read(4'h0, rd); check8("fe_ack", rd, m_status());

        @(negedge clk); uart_rx = 1'b0;
        @(negedge clk); uart_rx = 1'b1;
        repeat (30) @(negedge clk);
        bus_read(4'h0, rd); check8("glitch_status", rd, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/io_uart.md
# io_uart

Memory-mapped UART peripheral on the computer's external 8-bit I/O bus (`io_data`/`io_addr`/`io_oe`/`io_we`); it is the downstream consumer of the port accesses the CPU issues through the memory block. It decodes a 4-register window, queues transmit bytes in a 4-deep FIFO and serialises them 8N1. It also deserialises received frames into a holding register. All state advances on one clock.

## Interface
- `BASE`, 2'b00, value of `io_addr[3:2]` that selects this peripheral.
- `DIV_RESET`, 8'd15, reset value of BAUDDIV; bit period = BAUDDIV+1 clocks.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high; sampled on the rising edge of `clk`.
- `io_data`  inout  8  bidirectional data bus; this block drives it only during a selected read, otherwise 8'bz.
- `io_addr`  in  4  I/O port address; `[3:2]`=BASE selects, `[1:0]`=register.
- `io_oe`  in  1  1 = computer driving bus (write cycle possible); 0 = bus free for peripheral read.
- `io_we`  in  1  1 = write operation.
- `uart_rx`  in  1  asynchronous serial input, idle high.
- `uart_tx`  out  1  serial output, idle high.

## Operation
- Select: `sel = (io_addr[3:2]==BASE)`. Write strobe: `sel & io_oe & io_we`. Read drive: `sel & !io_oe`, combinational; register value on `io_data`.
- Register map (`io_addr[1:0]`):
  - 0 STATUS (R): bit0 tx_busy, bit1 tx_full, bit2 rx_valid, bit3 rx_overrun, bit4 rx_frame_err, bits7:5 = 0. Writes ignored.
  - 1 TXDATA (W): push byte into TX FIFO; dropped silently if FIFO full. Reads 8'h00.
  - 2 RXDATA (R): last received byte. Any write clears rx_valid, rx_overrun and rx_frame_err.
  - 3 BAUDDIV (R/W): 8-bit divider. Values below 3 are unsupported.
- Reads have no side effects. Acknowledge RX by writing RXDATA.
- TX FIFO: 4 entries, 3-bit count, 2-bit read/write pointers that wrap 3→0. tx_full = (count==4).
  - Push and pop in the same cycle: count unchanged.
  - Push while full is dropped even if a pop happens in the same cycle.
- TX FSM states: IDLE, START, DATA, STOP.
  - IDLE: if FIFO non-empty, pop into shift register and go to START.
  - START: `uart_tx`=0. DATA: 8 bits, LSB first. STOP: `uart_tx`=1.
  - Each state/bit lasts BAUDDIV+1 clocks.
  - At the end of STOP: if FIFO non-empty, pop and go directly to START (no idle gap); else go to IDLE.
  - tx_busy = (state!=IDLE) | FIFO non-empty.
- RX path: 2-flop synchroniser on `uart_rx`. RX FSM states: IDLE, START, DATA, STOP.
  - IDLE: a synchronised 1→0 edge enters START.
  - START: sample at (BAUDDIV+1)/2 clocks (integer division). If the sample is 1, treat as a glitch and return to IDLE.
  - DATA: 8 samples at full bit periods thereafter, LSB first.
  - STOP: sample once.
    - Stop=1: load RXDATA. If rx_valid was already 1, set rx_overrun and overwrite the byte. Set rx_valid.
    - Stop=0: set rx_frame_err; RXDATA unchanged.
  - Return to IDLE after the stop sample.
- Changing BAUDDIV mid-frame takes effect from the next bit-period reload; software must not do this.

## Timing
- Reset state:
  - `uart_tx`=1; `io_data`=Z.
  - FIFO empty; both FSMs IDLE.
  - RXDATA=8'h00; all status flags 0.
  - BAUDDIV=DIV_RESET; synchroniser flops=1.
- Reset asserted mid-frame: `uart_tx` is 1 on the cycle after the reset edge, and the partial frame is lost. Reset overrides any simultaneous bus write.
- TX latency: write to TXDATA at edge N with FIFO empty and TX IDLE:
  - Pop at edge N+1; `uart_tx` falls after edge N+1.
  - Frame length = 10×(BAUDDIV+1) clocks.
- Register write visible on read the cycle after the write edge. STATUS and RXDATA reads are combinational from registered state.
- RX flag latency: rx_valid sets 2 clocks (synchroniser) plus about 9.5 bit periods after the start-bit falling edge at the pin.
- RX-complete and an RXDATA-write acknowledge on the same edge: the new byte wins (rx_valid=1); the flags are cleared, then re-set if applicable.

## Test plan
- Reset mid-TX (BAUDDIV=3, byte 0xFF in flight) → `uart_tx`=1 next cycle, STATUS=0x00, BAUDDIV reads 8'd15.
- BAUDDIV=3, write TXDATA=0xA5 → `uart_tx` sequence 0,1,0,1,0,0,1,0,1,1, each bit held 4 clocks; tx_busy clears after 40 clocks.
- Write 5 bytes 0x01–0x05 back-to-back while TX idle → first pops immediately. 0x02–0x05 fill the FIFO, so no drop; tx_full=1 on the cycle after the 5th write. A 6th write 0x06 before any further pop is dropped. Frames 0x01–0x05 appear contiguously with no idle gap.
- Drive 8N1 frame 0x3C at BAUDDIV=7 on `uart_rx` → STATUS bit2=1, RXDATA reads 0x3C. Write RXDATA → STATUS=0x00.
- Two frames 0x11 then 0x22 with no acknowledge → RXDATA=0x22, STATUS bits2 and 3 set. A frame with stop bit 0 → bit4 set, RXDATA stays 0x22.
- `io_addr`[3:2]≠BASE, or `io_oe`=1 → `io_data` Z. A write with `io_we`=0 changes no register. A 1-clock low glitch on `uart_rx` → no rx_valid.
